// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg
// Shared types for the test sequencer: FSM state encoding and the
// severity codes that per-slot stimulus blocks report.
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        NEXT,
        DONE
    } state_t;

    localparam int SEV_W = 2;

    typedef enum logic [SEV_W-1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } sev_t;

endpackage

// File: rtl/test_sequencer_watchdog.sv
// test_sequencer_watchdog
// Per-slot cycle budget: a loadable down-counter that stops at zero.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          load the counter with load_val (takes priority over dec)
//   load_val      budget in cycles
//   dec           count down by one while nonzero
//   expired       combinational, high while the counter is zero
module test_sequencer_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [TIMEOUT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer
// Runs a bank of test slots one at a time on a shared harness. Each
// enabled slot gets a one-cycle go pulse, then the sequencer waits for
// that slot's done while counting the severity events it reports. A fatal
// event aborts the whole run. One finish pulse carries the pass verdict.
//
// Optional build macro TEST_SEQUENCER_WATCHDOG_EN: when defined, each
// slot has a cycle budget (i_timeout) and an overrun is recorded as a
// timeout plus one error. When undefined, i_timeout is ignored, o_timeout
// is tied low and a slot may run forever.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           run request, honoured only when idle
//   i_enable_mask     slots to run, latched on accepted start
//   i_timeout         per-slot cycle budget, latched on accepted start
//   i_done            per-slot completion (only the active slot counts)
//   i_sev_valid/i_sev per-slot severity strobe and 2-bit code
//   o_go              one-hot launch pulse
//   o_test_idx        active slot index
//   o_busy            high from accepted start through the finish pulse
//   o_finish, o_pass  run-complete pulse and verdict
//   o_*_cnt           saturating event counters
//   o_timeout         sticky slot timeout
//   o_fatal           sticky fatal abort
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int NUM_TESTS = 4,
    parameter int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NUM_TESTS-1:0]       i_enable_mask,
    input  logic [TIMEOUT_W-1:0]       i_timeout,
    input  logic [NUM_TESTS-1:0]       i_done,
    input  logic [NUM_TESTS-1:0]       i_sev_valid,
    input  logic [SEV_W*NUM_TESTS-1:0] i_sev,
    output logic [NUM_TESTS-1:0]       o_go,
    output logic [IDX_W-1:0]           o_test_idx,
    output logic                       o_busy,
    output logic                       o_finish,
    output logic                       o_pass,
    output logic [CNT_W-1:0]           o_info_cnt,
    output logic [CNT_W-1:0]           o_warn_cnt,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic                       o_timeout,
    output logic                       o_fatal
);

    state_t               state;
    logic [NUM_TESTS-1:0] mask_q;

    // Lowest enabled slot with index >= from. Result is {found, idx}.
    function automatic logic [IDX_W:0] find_slot(input logic [NUM_TESTS-1:0] mask,
                                                 input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_TESTS - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       amt);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, amt};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [IDX_W:0] first_slot;
    logic [IDX_W:0] next_slot;
    assign first_slot = find_slot(i_enable_mask, 0);
    assign next_slot  = find_slot(mask_q, int'(o_test_idx) + 1);

    // Active slot's view of the harness; other slots are invisible.
    logic act_valid;
    sev_t act_sev;
    logic in_run;
    logic fatal_hit, done_hit;
    logic ev_info, ev_warn, ev_err;
    logic wd_expired, wd_fire;
    logic start_ok;

    assign act_valid = i_sev_valid[o_test_idx];
    assign act_sev   = sev_t'(i_sev[o_test_idx*SEV_W +: SEV_W]);
    assign in_run    = (state == RUN);
    assign fatal_hit = in_run && act_valid && act_sev == SEV_FATAL;
    assign done_hit  = in_run && i_done[o_test_idx];
    assign ev_info   = in_run && act_valid && act_sev == SEV_INFO;
    assign ev_warn   = in_run && act_valid && act_sev == SEV_WARN;
    assign ev_err    = in_run && act_valid && act_sev == SEV_ERROR;
    // Expiry loses to both fatal and done in the same cycle.
    assign wd_fire   = in_run && wd_expired && !fatal_hit && !i_done[o_test_idx];
    // The finish cycle is already IDLE but still busy, so start waits one more cycle.
    assign start_ok  = (state == IDLE) && i_start && !o_finish;

`ifdef TEST_SEQUENCER_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] timeout_q;
    logic                 timeout_sticky;

    // Loaded in LAUNCH so the first RUN cycle sees the full budget; a zero
    // budget therefore expires on the first RUN cycle.
    test_sequencer_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (state == LAUNCH),
        .load_val (timeout_q),
        .dec      (in_run),
        .expired  (wd_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timeout_q      <= '0;
            timeout_sticky <= 1'b0;
        end else if (start_ok) begin
            timeout_q      <= i_timeout;
            timeout_sticky <= 1'b0;
        end else if (wd_fire) begin
            timeout_sticky <= 1'b1;
        end
    end

    assign o_timeout = timeout_sticky;
`else
    logic unused_timeout;
    assign unused_timeout = ^i_timeout;
    assign wd_expired     = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            o_go       <= '0;
            o_test_idx <= '0;
            o_busy     <= 1'b0;
            o_finish   <= 1'b0;
            o_pass     <= 1'b0;
            o_info_cnt <= '0;
            o_warn_cnt <= '0;
            o_err_cnt  <= '0;
            o_fatal    <= 1'b0;
        end else begin
            o_go     <= '0;
            o_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mask_q     <= i_enable_mask;
                        o_busy     <= 1'b1;
                        o_pass     <= 1'b0;
                        o_info_cnt <= '0;
                        o_warn_cnt <= '0;
                        o_err_cnt  <= '0;
                        o_fatal    <= 1'b0;
                        if (first_slot[IDX_W]) begin
                            o_test_idx <= first_slot[IDX_W-1:0];
                            o_go       <= NUM_TESTS'(1) << first_slot[IDX_W-1:0];
                            state      <= LAUNCH;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        // Drops busy at the end of the finish cycle.
                        o_busy <= 1'b0;
                    end
                end
                LAUNCH: state <= RUN;
                RUN: begin
                    o_info_cnt <= sat_add(o_info_cnt, {1'b0, ev_info});
                    o_warn_cnt <= sat_add(o_warn_cnt, {1'b0, ev_warn});
                    o_err_cnt  <= sat_add(o_err_cnt, {1'b0, ev_err} + {1'b0, wd_fire});
                    if (fatal_hit) begin
                        o_fatal <= 1'b1;
                        state   <= DONE;
                    end else if (done_hit || wd_fire) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (next_slot[IDX_W]) begin
                        o_test_idx <= next_slot[IDX_W-1:0];
                        o_go       <= NUM_TESTS'(1) << next_slot[IDX_W-1:0];
                        state      <= LAUNCH;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_finish <= 1'b1;
                    o_pass   <= (o_err_cnt == '0) && !o_fatal && !o_timeout;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  enable_mask;
    logic [15:0] timeout;
    logic [3:0]  done;
    logic [3:0]  sev_valid;
    logic [7:0]  sev;
    logic [3:0]  go;
    logic [1:0]  test_idx;
    logic        busy, finish, pass, tmo, fatal;
    logic [7:0]  info_cnt, warn_cnt, err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    test_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_enable_mask (enable_mask),
        .i_timeout     (timeout),
        .i_done        (done),
        .i_sev_valid   (sev_valid),
        .i_sev         (sev),
        .o_go          (go),
        .o_test_idx    (test_idx),
        .o_busy        (busy),
        .o_finish      (finish),
        .o_pass        (pass),
        .o_info_cnt    (info_cnt),
        .o_warn_cnt    (warn_cnt),
        .o_err_cnt     (err_cnt),
        .o_timeout     (tmo),
        .o_fatal       (fatal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [3:0] m, input logic [15:0] t);
        enable_mask = m;
        timeout     = t;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int max);
        int n;
        n = 0;
        while (finish !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        check({tag, " finish"}, finish, 1);
    endtask

    initial begin
        int go_log;
        int cd;
        int gi;

        rst = 1'b1; start = 1'b0; enable_mask = '0; timeout = '0;
        done = '0; sev_valid = '0; sev = '0;
        tick(); tick();
        check("rst busy", busy, 0);
        check("rst go", go, 0);
        check("rst idx", test_idx, 0);
        check("rst finish", finish, 0);
        check("rst pass", pass, 0);
        check("rst counters", {info_cnt, warn_cnt, err_cnt}, 0);
        check("rst sticky", {tmo, fatal}, 0);
        rst = 1'b0;
        tick();

        // Basic run: slots 0,1,3, done 5 cycles after each go.
        start_run(4'b1011, 16'd100);
        check("basic first go", go, 4'b0001);
        check("basic busy", busy, 1);
        go_log = 0;
        cd = 0;
        for (int c = 0; c < 200 && finish !== 1'b1; c++) begin
            done = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) done[test_idx] = 1'b1;
            end
            if (go != 4'b0000) begin
                gi = 0;
                for (int b = 0; b < 4; b++) if (go[b]) gi = b;
                go_log = go_log * 10 + gi + 1;
                cd = 5;
            end
            tick();
        end
        done = '0;
        check("basic finish", finish, 1);
        check("basic go order", go_log, 124);
        check("basic pass", pass, 1);
        check("basic busy at finish", busy, 1);
        check("basic counters", {info_cnt, warn_cnt, err_cnt}, 0);
        tick();
        check("basic single finish", finish, 0);
        check("basic idle busy", busy, 0);

        // Events on slot 1; slot 0 strobes are inactive and ignored.
        start_run(4'b0010, 16'd100);
        check("ev go", go, 4'b0010);
        check("ev idx", test_idx, 1);
        tick();
        sev_valid = 4'b0011; sev = 8'b0000_0110;  // slot1 warn, slot0 error
        tick();
        sev_valid = 4'b0010; sev = 8'b0000_0100;  // slot1 warn
        tick();
        sev_valid = 4'b0010; sev = 8'b0000_1000;  // slot1 error
        tick();
        sev_valid = 4'b0001; sev = 8'b0000_0010;  // slot0 error
        start = 1'b1;                             // ignored while busy
        tick();
        sev_valid = '0; sev = '0; start = 1'b0;
        check("ev warn", warn_cnt, 2);
        check("ev err", err_cnt, 1);
        check("ev info", info_cnt, 0);
        check("ev no relaunch", go, 0);
        done = 4'b0010;
        tick();
        done = '0;
        wait_finish("ev", 20);
        check("ev pass", pass, 0);

        // Fatal abort on slot 0.
        tick();
        start_run(4'b1111, 16'd100);
        check("fatal go", go, 4'b0001);
        tick();
        sev_valid = 4'b0001; sev = 8'b0000_0011;
        tick();
        sev_valid = '0; sev = '0;
        check("fatal sticky", fatal, 1);
        check("fatal no finish yet", finish, 0);
        check("fatal no go", go, 0);
        check("fatal no count", err_cnt, 0);
        tick();
        check("fatal finish", finish, 1);
        check("fatal pass", pass, 0);
        check("fatal no go 2", go, 0);
        tick();
        check("fatal finish once", finish, 0);
        check("fatal idle", busy, 0);
        check("fatal no go 3", go, 0);

        // Done and fatal in the same cycle: fatal wins.
        start_run(4'b0011, 16'd100);
        tick();
        sev_valid = 4'b0001; sev = 8'b0000_0011; done = 4'b0001;
        tick();
        sev_valid = '0; sev = '0; done = '0;
        check("df fatal", fatal, 1);
        check("df no go", go, 0);
        tick();
        check("df finish", finish, 1);
        check("df pass", pass, 0);
        tick();

        // Empty mask.
        start_run(4'b0000, 16'd100);
        check("m0 go", go, 0);
        check("m0 busy", busy, 1);
        tick();
        check("m0 finish", finish, 1);
        check("m0 pass", pass, 1);
        check("m0 go 2", go, 0);
        tick();

        // Done on the same cycle the budget (3) expires: no timeout.
        start_run(4'b0001, 16'd3);
        tick(); tick(); tick(); tick();
        done = 4'b0001;
        tick();
        done = '0;
        check("de timeout", tmo, 0);
        check("de err", err_cnt, 0);
        wait_finish("de", 20);
        check("de pass", pass, 1);
        tick();

`ifdef TEST_SEQUENCER_WATCHDOG_EN
        // Slot 0 never finishes; budget of 10 RUN cycles.
        start_run(4'b0011, 16'd10);
        check("wd go0", go, 4'b0001);
        for (int i = 0; i < 11; i++) tick();
        check("wd not early", tmo, 0);
        tick();
        check("wd timeout", tmo, 1);
        check("wd err", err_cnt, 1);
        tick();
        check("wd go1", go, 4'b0010);
        tick();
        done = 4'b0010;
        tick();
        done = '0;
        wait_finish("wd", 20);
        check("wd pass", pass, 0);
        check("wd err final", err_cnt, 1);
`else
        // Without a watchdog the slot waits indefinitely.
        start_run(4'b0011, 16'd10);
        check("nowd go0", go, 4'b0001);
        for (int i = 0; i < 20; i++) tick();
        check("nowd timeout", tmo, 0);
        check("nowd still busy", busy, 1);
        check("nowd no go", go, 0);
        done = 4'b0001;
        tick();
        done = '0;
        tick();
        check("nowd go1", go, 4'b0010);
        tick();
        done = 4'b0010;
        tick();
        done = '0;
        wait_finish("nowd", 20);
        check("nowd pass", pass, 1);
`endif
        tick();

        // Reset during RUN.
        start_run(4'b0001, 16'd100);
        tick();
        sev_valid = 4'b0001; sev = 8'b0000_0000;
        tick();
        sev_valid = '0;
        check("mid info", info_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr busy", busy, 0);
        check("mr go", go, 0);
        check("mr finish", finish, 0);
        check("mr info", info_cnt, 0);
        check("mr idx", test_idx, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr no finish", finish, 0);
        end

        // Info counter saturation.
        start_run(4'b0001, 16'hFFFF);
        tick();
        sev_valid = 4'b0001; sev = 8'b0000_0000;
        for (int i = 0; i < 300; i++) tick();
        sev_valid = '0;
        check("sat info", info_cnt, 255);
        done = 4'b0001;
        tick();
        done = '0;
        wait_finish("sat", 20);
        check("sat pass", pass, 1);
        check("sat info final", info_cnt, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
